// File: rtl/result_readback_if.sv
// Bus bundle for result_readback: control, memory read port and output byte stream.
interface result_readback_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned CNT_W  = 10
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  byte_count;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_index;
    logic [DATA_W-1:0] mem_out;
    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;

    // Readback engine side
    modport master (
        input  start, base_addr, byte_count, mem_out, out_ready,
        output mem_rd, mem_index, out_data, out_valid, out_last, busy, done
    );

    // Memory / host side
    modport slave (
        output start, base_addr, byte_count, mem_out, out_ready,
        input  mem_rd, mem_index, out_data, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/result_readback.sv
// Walks packed result words in data memory and streams them MSB-byte-first as a valid/ready byte stream.
module result_readback #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned CNT_W  = 10
) (
    input  logic               clk,
    input  logic               rst,
    result_readback_if.master  bus
);
    localparam int unsigned BYTES_PER_WORD = DATA_W / BYTE_W;
    localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);
    localparam int unsigned LAST_IDX       = BYTES_PER_WORD - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_n;
    logic [CNT_W-1:0]  r_remaining;
    logic [CNT_W-1:0]  w_remaining_n;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] w_word_n;
    logic [DATA_W-1:0] w_shifted;
    logic [IDX_W-1:0]  r_byte_idx;
    logic [IDX_W-1:0]  w_byte_idx_n;
    logic              w_xfer;

    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_index;
    logic [BYTE_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_busy;
    logic              r_done;

    assign w_xfer = r_out_valid & bus.out_ready;

    // Selected byte of the upcoming word/index, top byte after a left shift
    assign w_shifted = w_word_n << (32'(BYTE_W) * 32'(w_byte_idx_n));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and next datapath values
    always_comb begin
        w_next_state  = r_state;
        w_addr_n      = r_addr;
        w_remaining_n = r_remaining;
        w_word_n      = r_word;
        w_byte_idx_n  = r_byte_idx;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_addr_n      = bus.base_addr;
                    w_remaining_n = bus.byte_count;
                    w_next_state  = (bus.byte_count == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                w_word_n     = bus.mem_out;
                w_byte_idx_n = '0;
                w_addr_n     = r_addr + ADDR_W'(1);
                w_next_state = S_EMIT;
            end
            S_EMIT: begin
                if (w_xfer) begin
                    w_remaining_n = r_remaining - CNT_W'(1);
                    w_byte_idx_n  = r_byte_idx + IDX_W'(1);
                    if (r_remaining == CNT_W'(1)) begin
                        w_next_state = S_DONE;
                    end else if (r_byte_idx == IDX_W'(LAST_IDX)) begin
                        w_next_state = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath registers and outputs registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_word      <= '0;
            r_byte_idx  <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_index <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_addr      <= w_addr_n;
            r_remaining <= w_remaining_n;
            r_word      <= w_word_n;
            r_byte_idx  <= w_byte_idx_n;
            r_mem_rd    <= (w_next_state == S_FETCH);
            if (w_next_state == S_FETCH) begin
                r_mem_index <= w_addr_n;
            end
            if (w_next_state == S_EMIT) begin
                r_out_data <= w_shifted[DATA_W-1 -: BYTE_W];
            end
            r_out_valid <= (w_next_state == S_EMIT);
            r_out_last  <= (w_next_state == S_EMIT) && (w_remaining_n == CNT_W'(1));
            r_busy      <= (w_next_state != S_IDLE);
            r_done      <= (w_next_state == S_DONE);
        end
    end

    assign bus.mem_rd    = r_mem_rd;
    assign bus.mem_index = r_mem_index;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_result_readback.sv
// Testbench for result_readback: directed scenarios plus randomized transfers against a byte-list model.
module tb_result_readback;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 10;
    localparam int          NWORDS = 128;
    localparam int          BUDGET = 3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    result_readback_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BYTE_W(BYTE_W), .CNT_W(CNT_W)) bus ();

    result_readback #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BYTE_W(BYTE_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Synchronous-read memory model
    logic [DATA_W-1:0] mem [0:NWORDS-1];
    always @(posedge clk) begin
        if (bus.mem_rd === 1'b1) bus.mem_out <= mem[bus.mem_index];
    end

    // Consumer ready: fixed level or random
    logic ready_fixed;
    logic rand_ready;
    logic rnd_bit = 1'b1;
    always @(posedge clk) rnd_bit <= (($urandom % 4) != 0);
    assign bus.out_ready = rand_ready ? rnd_bit : ready_fixed;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int start_cyc = 0;

    // Monitor state
    logic [7:0] got_b[$];
    bit         got_l[$];
    int         xfer_rel[$];
    int         valid_rel[$];
    int         rd_idx[$];
    int         rd_rel[$];
    int         done_cnt  = 0;
    int         done_rel  = -1;
    int         stab_viol = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    // Observe the DUT on the falling edge
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (bus.mem_rd === 1'b1) begin
                rd_idx.push_back(int'(bus.mem_index));
                rd_rel.push_back(cyc - start_cyc);
            end
            if (bus.out_valid === 1'b1) begin
                valid_rel.push_back(cyc - start_cyc);
                if (prev_stall && (bus.out_data !== prev_data || bus.out_last !== prev_last))
                    stab_viol <= stab_viol + 1;
                if (bus.out_ready === 1'b1) begin
                    got_b.push_back(bus.out_data);
                    got_l.push_back(bus.out_last);
                    xfer_rel.push_back(cyc - start_cyc);
                end
            end else if (prev_stall) begin
                stab_viol <= stab_viol + 1;
            end
            prev_stall <= (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
            prev_data  <= bus.out_data;
            prev_last  <= bus.out_last;
            if (bus.done === 1'b1) begin
                done_cnt <= done_cnt + 1;
                done_rel <= cyc - start_cyc;
            end
        end else begin
            prev_stall <= 1'b0;
        end
    end

    // Reference: byte i of a transfer is byte (i mod 4), MSB first, of word base + i/4 (wrapping)
    function automatic logic [7:0] exp_byte(input int b, input int i);
        logic [31:0] w;
        w = mem[(b + i / 4) % NWORDS];
        return w[31 - 8 * (i % 4) -: 8];
    endfunction

    // Drive a one-cycle start; called and returns at posedge+1
    task automatic pulse_start(input int b, input int c);
        bus.base_addr  = ADDR_W'(b);
        bus.byte_count = CNT_W'(c);
        start_cyc      = cyc;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start      = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clk);
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        total += 7;
        if (bus.mem_rd !== 1'b0)    begin bad++; $display("FAIL reset_mem_rd: got %b want 0", bus.mem_rd); end
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        if (bus.out_last !== 1'b0)  begin bad++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
        if (bus.busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0)      begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        if (bus.mem_index !== '0)   begin bad++; $display("FAIL reset_mem_index: got %0h want 0", bus.mem_index); end
        if (bus.out_data !== '0)    begin bad++; $display("FAIL reset_out_data: got %0h want 0", bus.out_data); end
    endtask

    task automatic test_single_word();
        int b0, v0, r0, d0;
        bit ok;
        logic [7:0] exp_q[4];
        exp_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        mem[5] = 32'hA1B2C3D4;
        ready_fixed = 1'b1;
        b0 = got_b.size(); v0 = valid_rel.size(); r0 = rd_idx.size(); d0 = done_cnt;
        pulse_start(5, 4);
        wait_done(d0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_timeout: got no done want done"); return; end
        total += 5;
        if (rd_idx.size() != r0 + 1) begin bad++; $display("FAIL single_rd_count: got %0d want 1", rd_idx.size() - r0); end
        else begin
            if (rd_idx[r0] != 5) begin bad++; $display("FAIL single_rd_idx: got %0d want 5", rd_idx[r0]); end
            if (rd_rel[r0] != 1) begin bad++; $display("FAIL single_rd_cycle: got %0d want 1", rd_rel[r0]); end
        end
        if (valid_rel[v0] != 3) begin bad++; $display("FAIL single_first_valid: got %0d want 3", valid_rel[v0]); end
        if (done_rel != 7) begin bad++; $display("FAIL single_done_cycle: got %0d want 7", done_rel); end
        if (got_b.size() != b0 + 4) begin bad++; $display("FAIL single_nbytes: got %0d want 4", got_b.size() - b0); return; end
        for (int i = 0; i < 4; i++) begin
            total += 3;
            if (got_b[b0+i] !== exp_q[i]) begin bad++; $display("FAIL single_byte%0d: got %0h want %0h", i, got_b[b0+i], exp_q[i]); end
            if (got_l[b0+i] !== (i == 3)) begin bad++; $display("FAIL single_last%0d: got %0d want %0d", i, got_l[b0+i], i == 3); end
            if (xfer_rel[b0+i] != 3 + i) begin bad++; $display("FAIL single_xfer_cycle%0d: got %0d want %0d", i, xfer_rel[b0+i], 3 + i); end
        end
    endtask

    task automatic test_partial_word();
        int b0, r0, d0;
        bit ok;
        logic [7:0] exp_q[6];
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        mem[10] = 32'h11223344;
        mem[11] = 32'h55667788;
        b0 = got_b.size(); r0 = rd_idx.size(); d0 = done_cnt;
        pulse_start(10, 6);
        wait_done(d0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL partial_timeout: got no done want done"); return; end
        total += 2;
        if (rd_idx.size() != r0 + 2) begin bad++; $display("FAIL partial_rd_count: got %0d want 2", rd_idx.size() - r0); end
        else if (rd_idx[r0+1] != 11) begin bad++; $display("FAIL partial_rd_idx2: got %0d want 11", rd_idx[r0+1]); end
        if (got_b.size() != b0 + 6) begin bad++; $display("FAIL partial_nbytes: got %0d want 6", got_b.size() - b0); return; end
        for (int i = 0; i < 6; i++) begin
            total += 2;
            if (got_b[b0+i] !== exp_q[i]) begin bad++; $display("FAIL partial_byte%0d: got %0h want %0h", i, got_b[b0+i], exp_q[i]); end
            if (got_l[b0+i] !== (i == 5)) begin bad++; $display("FAIL partial_last%0d: got %0d want %0d", i, got_l[b0+i], i == 5); end
        end
    endtask

    task automatic test_backpressure();
        int b0, v0, d0, s0;
        bit ok;
        mem[5] = 32'hA1B2C3D4;
        ready_fixed = 1'b0;
        b0 = got_b.size(); v0 = valid_rel.size(); d0 = done_cnt; s0 = stab_viol;
        pulse_start(5, 4);
        repeat (5) @(posedge clk);
        #1 ready_fixed = 1'b1;
        wait_done(d0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_timeout: got no done want done"); return; end
        total += 5;
        if (valid_rel.size() - v0 != 7) begin bad++; $display("FAIL bp_valid_cycles: got %0d want 7", valid_rel.size() - v0); end
        if (valid_rel[v0] != 3) begin bad++; $display("FAIL bp_first_valid: got %0d want 3", valid_rel[v0]); end
        if (done_rel != 10) begin bad++; $display("FAIL bp_done_cycle: got %0d want 10", done_rel); end
        if (stab_viol != s0) begin bad++; $display("FAIL bp_stable: got %0d violations want 0", stab_viol - s0); end
        if (got_b.size() != b0 + 4) begin bad++; $display("FAIL bp_nbytes: got %0d want 4", got_b.size() - b0); return; end
        total += 2;
        if (xfer_rel[b0] != 6) begin bad++; $display("FAIL bp_first_xfer: got %0d want 6", xfer_rel[b0]); end
        if (got_b[b0] !== 8'hA1 || got_b[b0+3] !== 8'hD4 || got_l[b0+3] !== 1'b1) begin
            bad++; $display("FAIL bp_bytes: got %0h..%0h last %0d want a1..d4 last 1", got_b[b0], got_b[b0+3], got_l[b0+3]);
        end
    endtask

    task automatic test_zero_count();
        int v0, r0, d0;
        bit ok;
        v0 = valid_rel.size(); r0 = rd_idx.size(); d0 = done_cnt;
        pulse_start(3, 0);
        wait_done(d0, ok);
        repeat (2) @(posedge clk);
        #1;
        total += 4;
        if (!ok) begin bad++; $display("FAIL zero_timeout: got no done want done"); end
        if (rd_idx.size() != r0) begin bad++; $display("FAIL zero_mem_rd: got %0d reads want 0", rd_idx.size() - r0); end
        if (valid_rel.size() != v0) begin bad++; $display("FAIL zero_valid: got %0d valid cycles want 0", valid_rel.size() - v0); end
        if (done_rel != 1) begin bad++; $display("FAIL zero_done_cycle: got %0d want 1", done_rel); end
    endtask

    task automatic test_addr_wrap();
        int b0, r0, d0;
        bit ok;
        mem[127] = 32'hCAFEBABE;
        mem[0]   = 32'h0BADF00D;
        b0 = got_b.size(); r0 = rd_idx.size(); d0 = done_cnt;
        pulse_start(127, 8);
        wait_done(d0, ok);
        repeat (2) @(posedge clk);
        #1;
        total += 3;
        if (!ok) begin bad++; $display("FAIL wrap_timeout: got no done want done"); return; end
        if (done_cnt != d0 + 1) begin bad++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt - d0); end
        if (rd_idx.size() != r0 + 2 || rd_idx[r0] != 127 || rd_idx[r0+1] != 0) begin
            bad++; $display("FAIL wrap_rd_idx: got %0d reads want 2 reads at 127,0", rd_idx.size() - r0);
        end
        total++;
        if (got_b.size() != b0 + 8) begin bad++; $display("FAIL wrap_nbytes: got %0d want 8", got_b.size() - b0); return; end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (got_b[b0+i] !== exp_byte(127, i)) begin bad++; $display("FAIL wrap_byte%0d: got %0h want %0h", i, got_b[b0+i], exp_byte(127, i)); end
        end
    endtask

    task automatic test_busy_and_abort();
        int b0, r0, d0;
        bit ok;
        mem[5] = 32'hA1B2C3D4;
        ready_fixed = 1'b1;
        // start while busy must be ignored
        b0 = got_b.size(); r0 = rd_idx.size(); d0 = done_cnt;
        pulse_start(5, 4);
        bus.base_addr = 7'd10; bus.byte_count = 10'd6; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done(d0, ok);
        repeat (3) @(posedge clk);
        #1;
        total += 4;
        if (!ok) begin bad++; $display("FAIL busy_timeout: got no done want done"); end
        if (done_cnt != d0 + 1) begin bad++; $display("FAIL busy_done_count: got %0d want 1", done_cnt - d0); end
        if (rd_idx.size() != r0 + 1) begin bad++; $display("FAIL busy_rd_count: got %0d want 1", rd_idx.size() - r0); end
        if (got_b.size() != b0 + 4 || got_b[b0+3] !== 8'hD4) begin
            bad++; $display("FAIL busy_bytes: got %0d bytes want 4 ending d4", got_b.size() - b0);
        end

        // reset during EMIT aborts the transfer
        r0 = rd_idx.size(); d0 = done_cnt;
        pulse_start(5, 4);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) ok = 1'b1;
        end
        total++;
        if (!ok) begin bad++; $display("FAIL abort_no_emit: got no out_valid want out_valid"); end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({bus.mem_rd, bus.out_valid, bus.out_last, bus.busy, bus.done} !== 5'b0 || bus.out_data !== '0 || bus.mem_index !== '0) begin
            bad++; $display("FAIL abort_outputs: got rd%b v%b l%b b%b d%b data %0h want all 0",
                            bus.mem_rd, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.out_data);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        total += 2;
        if (done_cnt != d0) begin bad++; $display("FAIL abort_done: got %0d done pulses want 0", done_cnt - d0); end
        if (rd_idx.size() != r0 + 1) begin bad++; $display("FAIL abort_rd: got %0d reads want 1", rd_idx.size() - r0); end
    endtask

    task automatic test_random();
        int b0, r0, d0, s0, base, cnt, nw;
        bit ok;
        rand_ready = 1'b1;
        for (int it = 0; it < 16; it++) begin
            for (int w = 0; w < NWORDS; w++) mem[w] = $urandom;
            base = $urandom % NWORDS;
            cnt  = (it == 0) ? 13 : int'($urandom_range(1, 40));
            nw   = (cnt + 3) / 4;
            b0 = got_b.size(); r0 = rd_idx.size(); d0 = done_cnt; s0 = stab_viol;
            pulse_start(base, cnt);
            wait_done(d0, ok);
            repeat (2) @(posedge clk);
            #1;
            total += 4;
            if (!ok) begin bad++; $display("FAIL rand%0d_timeout: got no done want done", it); continue; end
            if (done_cnt != d0 + 1) begin bad++; $display("FAIL rand%0d_done_count: got %0d want 1", it, done_cnt - d0); end
            if (stab_viol != s0) begin bad++; $display("FAIL rand%0d_stable: got %0d violations want 0", it, stab_viol - s0); end
            if (rd_idx.size() != r0 + nw) begin bad++; $display("FAIL rand%0d_rd_count: got %0d want %0d", it, rd_idx.size() - r0, nw); end
            else begin
                for (int w = 0; w < nw; w++) begin
                    total++;
                    if (rd_idx[r0+w] != (base + w) % NWORDS) begin
                        bad++; $display("FAIL rand%0d_rd_idx%0d: got %0d want %0d", it, w, rd_idx[r0+w], (base + w) % NWORDS);
                    end
                end
            end
            total++;
            if (got_b.size() != b0 + cnt) begin bad++; $display("FAIL rand%0d_nbytes: got %0d want %0d", it, got_b.size() - b0, cnt); continue; end
            for (int i = 0; i < cnt; i++) begin
                total += 2;
                if (got_b[b0+i] !== exp_byte(base, i)) begin
                    bad++; $display("FAIL rand%0d_byte%0d: got %0h want %0h", it, i, got_b[b0+i], exp_byte(base, i));
                end
                if (got_l[b0+i] !== (i == cnt - 1)) begin
                    bad++; $display("FAIL rand%0d_last%0d: got %0d want %0d", it, i, got_l[b0+i], i == cnt - 1);
                end
            end
        end
        rand_ready = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.byte_count = '0;
        ready_fixed    = 1'b1;
        rand_ready     = 1'b0;
        for (int w = 0; w < NWORDS; w++) mem[w] = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_single_word();
        test_partial_word();
        test_backpressure();
        test_zero_count();
        test_addr_wrap();
        test_busy_and_abort();
        test_single_word();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
